// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's external buses.
//   Instruction memory : imem_addr (out of fetch), imem_rdata (into fetch)
//   Redirect from EX   : redirect_valid, redirect_pc (into fetch)
//   Decode handshake   : id_valid, id_instr, id_pc (out of fetch), id_ready (into fetch)
//   Status             : misalign (out of fetch)
// The master modport is the fetch unit's view; slave is the surrounding
// pipeline/memory view.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        misalign;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output misalign
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the PC, presents it as the word-aligned fetch address to a
// combinational instruction memory, captures {pc, instruction} into a small
// prefetch FIFO and hands the head entry to decode over valid/ready.
// A redirect from execute flushes the FIFO and reloads the PC.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_unit_if.master (imem, redirect, decode handshake, misalign)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

  // Control state
  logic [31:0]      pc_reg,       pc_next;
  logic [CNT_W-1:0] count_reg,    count_next;
  logic [PTR_W-1:0] rd_ptr_reg,   rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg,   wr_ptr_next;
  logic             misalign_reg, misalign_next;

  // Prefetch storage; read asynchronously at the head so decode sees the
  // entry in the same cycle it becomes valid.
  logic [31:0] buf_pc_reg    [BUF_DEPTH];
  logic [31:0] buf_instr_reg [BUF_DEPTH];

  logic push;
  logic pop;
  logic id_valid_int;

  // A redirect hides the head immediately so no transfer completes in the
  // same cycle the FIFO is being flushed.
  assign id_valid_int = (count_reg != '0) && !bus.redirect_valid;
  assign pop          = id_valid_int && bus.id_ready;
  // Full-and-popping still pushes, keeping one-per-cycle throughput.
  assign push         = !bus.redirect_valid && ((count_reg < FULL_COUNT) || pop);

  assign bus.imem_addr = pc_reg;
  assign bus.id_valid  = id_valid_int;
  assign bus.id_instr  = buf_instr_reg[rd_ptr_reg];
  assign bus.id_pc     = buf_pc_reg[rd_ptr_reg];
  assign bus.misalign  = misalign_reg;

  always_comb begin
    pc_next       = pc_reg;
    count_next    = count_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    misalign_next = misalign_reg;

    if (bus.redirect_valid) begin
      pc_next     = {bus.redirect_pc[31:2], 2'b00};
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misalign_next = 1'b1;
      end
    end else begin
      if (push) begin
        // 32-bit wrap from FFFF_FFFC to 0 is intentional and unflagged.
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      misalign_reg <= misalign_next;
    end
  end

  // Payload needs no reset: it is only observable while id_valid=1, and
  // count is cleared by reset.
  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          buf_pc_reg[gi]    <= pc_reg;
          buf_instr_reg[gi] <= bus.imem_rdata;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: small program at 0..C, address-derived
  // pattern everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] w;
    if (addr < 32'd16) begin
      case (addr[3:2])
        2'd0:    w = 32'h0000_0013;
        2'd1:    w = 32'h0010_0093;
        2'd2:    w = 32'h0020_0113;
        default: w = 32'h0020_81B3;
      endcase
    end else begin
      w = addr ^ 32'h5A5A_0000;
    end
    return w;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that starts cycle 0.
  task automatic apply_reset;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    // not used for checking (kept trivial); see inline comparisons
  endtask

  task automatic test_reset;
    logic [31:0] exp_instr [4];
    exp_instr[0] = 32'h0000_0013;
    exp_instr[1] = 32'h0010_0093;
    exp_instr[2] = 32'h0020_0113;
    exp_instr[3] = 32'h0020_81B3;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #2;
    vectors++;
    if (bus.id_valid !== 1'b0 || bus.misalign !== 1'b0 || bus.imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b misalign=%b addr=%h want 0/0/00000000", bus.id_valid, bus.misalign, bus.imem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.id_ready = 1'b1;
    #2;
    vectors++;
    if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_cycle0: got valid=%b addr=%h want 0/00000000", bus.id_valid, bus.imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      $display("reset_stream: cycle %0d valid=%b pc=%h instr=%h", i + 1, bus.id_valid, bus.id_pc, bus.id_instr);
      vectors++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(i * 4) || bus.id_instr !== exp_instr[i]) begin
        miscompares++;
        $display("FAIL reset_stream[%0d]: got valid=%b pc=%h instr=%h want 1/%h/%h", i, bus.id_valid, bus.id_pc, bus.id_instr, 32'(i * 4), exp_instr[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    apply_reset();
    bus.id_ready = 1'b0;
    tick(); // cycle 1
    tick(); // cycle 2: buffer full
    for (int c = 2; c < 5; c++) begin
      #2;
      $display("backpressure: cycle %0d count=%0d addr=%h pc=%h", c, dut.count_reg, bus.imem_addr, bus.id_pc);
      vectors++;
      if (dut.count_reg !== 2'd2 || bus.imem_addr !== 32'h8 || bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: got count=%0d addr=%h pc=%h valid=%b want 2/00000008/00000000/1", c, dut.count_reg, bus.imem_addr, bus.id_pc, bus.id_valid);
      end
      tick();
    end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      $display("backpressure_resume: pc=%h instr=%h", bus.id_pc, bus.id_instr);
      vectors++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(i * 4) || bus.id_instr !== mem_word(32'(i * 4))) begin
        miscompares++;
        $display("FAIL backpressure_resume[%0d]: got valid=%b pc=%h instr=%h want 1/%h/%h", i, bus.id_valid, bus.id_pc, bus.id_instr, 32'(i * 4), mem_word(32'(i * 4)));
      end
      tick();
    end
  endtask

  task automatic test_full_push_pop;
    apply_reset();
    bus.id_ready = 1'b0;
    tick();
    tick();
    tick(); // cycle 3: full, pc=8
    bus.id_ready = 1'b1;
    #2;
    vectors++;
    if (bus.id_pc !== 32'h0 || bus.imem_addr !== 32'h8 || dut.count_reg !== 2'd2) begin
      miscompares++;
      $display("FAIL full_before: got pc=%h addr=%h count=%0d want 00000000/00000008/2", bus.id_pc, bus.imem_addr, dut.count_reg);
    end
    tick();
    bus.id_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      $display("full_push_pop: pc=%h addr=%h count=%0d", bus.id_pc, bus.imem_addr, dut.count_reg);
      vectors++;
      if (bus.id_pc !== 32'h4 || bus.imem_addr !== 32'hC || dut.count_reg !== 2'd2 || bus.id_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL full_after[%0d]: got pc=%h addr=%h count=%0d valid=%b want 00000004/0000000c/2/1", c, bus.id_pc, bus.imem_addr, dut.count_reg, bus.id_valid);
      end
      tick();
    end
  endtask

  task automatic test_redirect_full;
    apply_reset();
    bus.id_ready = 1'b0;
    tick();
    tick();
    tick(); // full with entries at 0 and 4
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    #2;
    vectors++;
    if (bus.id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_N: got valid=%b want 0", bus.id_valid);
    end
    tick();
    bus.redirect_valid = 1'b0;
    #2;
    vectors++;
    if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL redirect_N1: got valid=%b addr=%h want 0/00000040", bus.id_valid, bus.imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      #2;
      $display("redirect_full: valid=%b pc=%h instr=%h", bus.id_valid, bus.id_pc, bus.id_instr);
      vectors++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(32'h40 + i * 4) || bus.id_instr !== mem_word(32'(32'h40 + i * 4))) begin
        miscompares++;
        $display("FAIL redirect_deliver[%0d]: got valid=%b pc=%h instr=%h want 1/%h/%h", i, bus.id_valid, bus.id_pc, bus.id_instr, 32'(32'h40 + i * 4), mem_word(32'(32'h40 + i * 4)));
      end
    end
  endtask

  task automatic test_misalign_wrap;
    apply_reset();
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h46;
    tick();
    bus.redirect_valid = 1'b0;
    #2;
    vectors++;
    if (bus.misalign !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_set: got %b want 1", bus.misalign);
    end
    tick();
    #2;
    vectors++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h44) begin
      miscompares++;
      $display("FAIL misalign_pc: got valid=%b pc=%h want 1/00000044", bus.id_valid, bus.id_pc);
    end
    // Aligned redirect to the top of memory: misalign must persist, PC wraps.
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    #2;
    $display("wrap: valid=%b pc=%h misalign=%b", bus.id_valid, bus.id_pc, bus.misalign);
    vectors++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_instr !== mem_word(32'hFFFF_FFFC) || bus.misalign !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_top: got valid=%b pc=%h instr=%h misalign=%b want 1/fffffffc/%h/1", bus.id_valid, bus.id_pc, bus.id_instr, bus.misalign, mem_word(32'hFFFF_FFFC));
    end
    tick();
    #2;
    $display("wrap: valid=%b pc=%h", bus.id_valid, bus.id_pc);
    vectors++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0000_0013) begin
      miscompares++;
      $display("FAIL wrap_zero: got valid=%b pc=%h instr=%h want 1/00000000/00000013", bus.id_valid, bus.id_pc, bus.id_instr);
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h22;
    tick();
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b0;
    tick();
    tick();
    tick(); // full with 0x20, 0x24
    #2;
    vectors++;
    if (bus.id_valid !== 1'b1 || bus.misalign !== 1'b1 || bus.id_pc !== 32'h20 || bus.imem_addr !== 32'h28) begin
      miscompares++;
      $display("FAIL async_pre: got valid=%b misalign=%b pc=%h addr=%h want 1/1/00000020/00000028", bus.id_valid, bus.misalign, bus.id_pc, bus.imem_addr);
    end
    #1;
    rst = 1'b1; // between clock edges
    #1;
    vectors++;
    if (bus.id_valid !== 1'b0 || bus.misalign !== 1'b0 || bus.imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b misalign=%b addr=%h want 0/0/00000000", bus.id_valid, bus.misalign, bus.imem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      #2;
      $display("async_restart: valid=%b pc=%h", bus.id_valid, bus.id_pc);
      vectors++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(i * 4) || bus.id_instr !== mem_word(32'(i * 4))) begin
        miscompares++;
        $display("FAIL async_restart[%0d]: got valid=%b pc=%h instr=%h want 1/%h/%h", i, bus.id_valid, bus.id_pc, bus.id_instr, 32'(i * 4), mem_word(32'(i * 4)));
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_backpressure();
    test_full_push_pop();
    test_redirect_full();
    test_misalign_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the instruction memory. It owns the program counter and drives the word-aligned fetch address into the combinational instruction memory. It captures the returned instruction word together with its PC into a small prefetch buffer. It hands entries to decode over a valid/ready handshake, and it flushes and redirects on branch/jump requests from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
BUF_DEPTH, 2, prefetch buffer entries (power of two, ≥2).

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
imem_addr  output  32  byte address to instruction memory; memory returns the word at imem_addr>>2 in the same cycle.
imem_rdata  input  32  instruction word from instruction memory (combinational response to imem_addr).
redirect_valid  input  1  execute requests a PC change this cycle.
redirect_pc  input  32  target byte address for redirect.
id_valid  output  1  buffer head holds a valid instruction for decode.
id_ready  input  1  decode accepts the head entry this cycle.
id_instr  output  32  instruction word at buffer head.
id_pc  output  32  PC of id_instr.
misalign  output  1  sticky flag: a redirect target had bits[1:0] ≠ 0.

Behaviour:
- One clock domain (clk); reset asynchronous, active-high (rst). While rst=1: pc=RESET_PC, buffer count=0, rd/wr pointers=0, misalign=0, id_valid=0. id_instr/id_pc are don't-care while id_valid=0.
- imem_addr = pc, combinational from the pc register; pc[1:0] is always 00.
- Push: every cycle with redirect_valid=0 and (count<BUF_DEPTH or pop this cycle), write {pc, imem_rdata} at wr_ptr and set pc<=pc+4. Otherwise pc holds, and imem_addr is re-presented unchanged.
- Pop: pop = id_valid & id_ready. It advances rd_ptr.
- id_valid = (count≠0) & ~redirect_valid. This masking is combinational, so no transfer completes in a redirect cycle.
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop. Simultaneous push and pop when full is legal and keeps count=BUF_DEPTH.
- Pointers wrap modulo BUF_DEPTH.
- Redirect (redirect_valid=1) has priority over push and pop:
  - count<=0 and pointers<=0;
  - the current imem_rdata is discarded;
  - pc<={redirect_pc[31:2],2'b00}.
- If redirect_pc[1:0]≠0, misalign<=1. It stays 1 until rst.
- Back-to-back redirects: each cycle's target overrides the previous one; no push occurs until the first cycle with redirect_valid=0.
- Latency:
  - After rst deasserts, cycle 0 fetches RESET_PC and id_valid=1 from cycle 1.
  - After a redirect in cycle N, the target instruction is presented with id_valid=1 in cycle N+2.
  - With id_ready held at 1, throughput is one instruction per cycle.
- PC arithmetic is 32-bit unsigned: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
- Output stability: while id_valid=1 and id_ready=0, id_instr/id_pc hold stable until popped or flushed. rst mid-operation clears all state immediately, without waiting for a clock.
- No other state machine exists. Control state is {count, rd_ptr, wr_ptr, pc, misalign}.

Test Plan:
- Reset/stream: imem preloaded with NOP, 00100093, 00200113, 002081B3; RESET_PC=0, id_ready=1. Required: id_valid rises in cycle 1; (id_pc,id_instr) = (0,00000013), (4,00100093), (8,00200113), (C,002081B3) on consecutive cycles.
- Backpressure: id_ready=0 for 5 cycles after reset. Required: count saturates at 2, imem_addr holds at 8, and id_pc=0 stays stable. Then id_ready=1: the stream resumes 0,4,8,C with no gap or duplicate.
- Full + simultaneous push/pop: hold the buffer full, then pulse id_ready for 1 cycle. Required: exactly one entry is consumed, pc advances by 4, and count stays 2.
- Redirect with full buffer: redirect_valid=1, redirect_pc=0x40 in cycle N while id_ready=1. Required: id_valid=0 in N and N+1; the pending entries at PCs 0/4 are never delivered; id_pc=0x40 in N+2.
- Misaligned redirect and wrap-around:
  - redirect_pc=0x46: next id_pc=0x44 and misalign=1, which persists after a later aligned redirect.
  - redirect_pc=0xFFFF_FFFC: delivered id_pc sequence is FFFF_FFFC then 0000_0000.
- Reset mid-operation: assert rst asynchronously between clock edges while the buffer is full. Required: id_valid=0 and misalign=0 immediately, and imem_addr=RESET_PC. Normal streaming restarts from RESET_PC after release.
